// File: rtl/mux_scan_capture.sv
// Scans an external 8:1 mux one channel at a time and captures a registered 8-bit word.
// Optional MUX_SCAN_PARITY_EN adds a registered even-parity output alongside data_out.
module mux_scan_capture #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Y,
  output logic [2:0] S,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [2:0] s_nx;
  logic [7:0] shadow, shadow_nx;
  logic [7:0] data_nx;
  logic       valid_nx;
  logic       busy_nx;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    s_nx      = S;
    shadow_nx = shadow;
    data_nx   = data_out;
    valid_nx  = data_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SCAN;
          s_nx     = '0;
          cnt_nx   = '0;
        end
      end
      SCAN: begin
        if (cnt == SETTLE_C) begin
          cnt_nx       = '0;
          shadow_nx[S] = Y;
          if (S == 3'd7) begin
            // shadow_nx already carries the live Y in bit 7
            data_nx  = shadow_nx;
            valid_nx = 1'b1;
            state_nx = HOLD;
            s_nx     = '0;
          end else begin
            s_nx = S + 3'd1;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (data_valid && data_ready) begin
          valid_nx = 1'b0;
          if (start) begin
            state_nx = SCAN;
            s_nx     = '0;
            cnt_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        s_nx     = '0;
        cnt_nx   = '0;
        valid_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      S          <= '0;
      shadow     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      S          <= s_nx;
      shadow     <= shadow_nx;
      data_out   <= data_nx;
      data_valid <= valid_nx;
      busy       <= busy_nx;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ^data_nx;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// Randomized self-checking bench: two instances (SETTLE=1 and SETTLE=0) each scan a modelled mux81.
// Expected S timing and captured words are derived arithmetically from the scan rules.
module tb_mux_scan_capture;

  logic       clk;
  logic       rst;
  logic       start_r [2];
  logic       ready_r [2];
  logic [7:0] i_word  [2];
  logic       y_w     [2];
  logic [2:0] s_o     [2];
  logic       busy_o  [2];
  logic [7:0] data_o  [2];
  logic       valid_o [2];
`ifdef MUX_SCAN_PARITY_EN
  logic       par_o   [2];
`endif

  int n_vec = 0;
  int n_err = 0;

  mux_scan_capture #(.SETTLE(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_r[0]),
    .Y         (y_w[0]),
    .S         (s_o[0]),
    .busy      (busy_o[0]),
    .data_out  (data_o[0]),
    .data_valid(valid_o[0]),
    .data_ready(ready_r[0])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity    (par_o[0])
`endif
  );

  mux_scan_capture #(.SETTLE(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start_r[1]),
    .Y         (y_w[1]),
    .S         (s_o[1]),
    .busy      (busy_o[1]),
    .data_out  (data_o[1]),
    .data_valid(valid_o[1]),
    .data_ready(ready_r[1])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity    (par_o[1])
`endif
  );

  // mux81 models
  assign y_w[0] = i_word[0][s_o[0]];
  assign y_w[1] = i_word[1][s_o[1]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 1 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input int idx);
    check("idle_busy", 32'(busy_o[idx]), 0);
    check("idle_valid", 32'(valid_o[idx]), 0);
  endtask

  // Called at the negedge right after the start edge; returns at the negedge after the capture edge.
  task automatic scan_check(input int idx, input logic [7:0] w, input bit noise);
    int hold_len;
    int n;
    hold_len = settle_of(idx) + 1;
    n = 8 * hold_len;
    for (int k = 0; k < n; k++) begin
      check("scan_S", 32'(s_o[idx]), 32'(k / hold_len));
      check("scan_busy", 32'(busy_o[idx]), 1);
      check("scan_valid", 32'(valid_o[idx]), 0);
      if (noise) begin
        start_r[idx] = 1'($urandom_range(0, 1));
        ready_r[idx] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    check("cap_valid", 32'(valid_o[idx]), 1);
    check("cap_data", 32'(data_o[idx]), 32'(w));
    check("cap_S", 32'(s_o[idx]), 0);
    check("cap_busy", 32'(busy_o[idx]), 1);
`ifdef MUX_SCAN_PARITY_EN
    check("cap_parity", 32'(par_o[idx]), 32'(^w));
`endif
  endtask

  task automatic start_scan(input int idx, input logic [7:0] w);
    i_word[idx]  = w;
    start_r[idx] = 1'b1;
    ready_r[idx] = 1'b0;
    @(negedge clk);
    start_r[idx] = 1'b0;
  endtask

  task automatic hold_release(input int idx, input logic [7:0] w, input int wait_n);
    start_r[idx] = 1'b0;
    ready_r[idx] = 1'b0;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(valid_o[idx]), 1);
      check("hold_data", 32'(data_o[idx]), 32'(w));
    end
    ready_r[idx] = 1'b1;
    @(negedge clk);
    ready_r[idx] = 1'b0;
    check_idle(idx);
  endtask

  task automatic back_to_back(input int idx, input logic [7:0] w1, input logic [7:0] w2);
    i_word[idx]  = w1;
    start_r[idx] = 1'b1;
    ready_r[idx] = 1'b1;
    @(negedge clk);
    scan_check(idx, w1, 1'b0);
    i_word[idx] = w2;
    @(negedge clk);
    scan_check(idx, w2, 1'b0);
    start_r[idx] = 1'b0;
    @(negedge clk);
    ready_r[idx] = 1'b0;
    check_idle(idx);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0;
      ready_r[i] = 1'b0;
      i_word[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_idle(i);
      check("rst_S", 32'(s_o[i]), 0);
      check("rst_data", 32'(data_o[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    start_scan(0, 8'hA5);
    scan_check(0, 8'hA5, 1'b0);
    hold_release(0, 8'hA5, 0);

    start_scan(1, 8'h3C);
    scan_check(1, 8'h3C, 1'b0);
    hold_release(1, 8'h3C, 10);

    back_to_back(0, 8'hFF, 8'h01);
    back_to_back(1, 8'($urandom), 8'($urandom));

    // data_ready pulses while idle must not produce a word
    for (int i = 0; i < 2; i++) begin
      ready_r[i] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check_idle(i);
      end
      ready_r[i] = 1'b0;
    end

    for (int r = 0; r < 12; r++) begin
      int idx;
      idx = r % 2;
      w = 8'($urandom);
      start_scan(idx, w);
      scan_check(idx, w, 1'b1);
      hold_release(idx, w, int'($urandom_range(0, 5)));
    end

    // asynchronous reset mid-scan while S == 4
    start_scan(0, 8'h5A);
    for (int k = 0; k < 4 * (settle_of(0) + 1); k++) @(negedge clk);
    check("pre_rst_S", 32'(s_o[0]), 4);
    #2 rst = 1'b1;
    #1;
    check("arst_S", 32'(s_o[0]), 0);
    check("arst_busy", 32'(busy_o[0]), 0);
    check("arst_valid", 32'(valid_o[0]), 0);
    check("arst_data", 32'(data_o[0]), 0);
`ifdef MUX_SCAN_PARITY_EN
    check("arst_parity", 32'(par_o[0]), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(valid_o[0]), 0);
      check("post_rst_busy", 32'(busy_o[0]), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_capture.md
MUX_SCAN_CAPTURE -- requirements
Module: mux_scan_capture

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of extra cycles each select value is held before Y is sampled (legal range 0..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one 8-channel scan; sampled only in IDLE.
REQ-005 The block SHALL have port Y, input, 1 bit: output of the downstream-facing mux81, i.e. the selected channel bit.
REQ-006 The block SHALL have port S, output, 3 bits: channel select driven to mux81.
REQ-007 The block SHALL have port busy, output, 1 bit: high in SCAN and HOLD.
REQ-008 The block SHALL have port data_out, output, 8 bits: captured word; bit n = Y sampled while S == n.
REQ-009 The block SHALL have port data_valid, output, 1 bit: data_out holds a complete word.
REQ-010 The block SHALL have port data_ready, input, 1 bit: consumer accepts data_out.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN and HOLD; all outputs SHALL be registered.
REQ-012 In IDLE with start=1, the block SHALL enter SCAN at the next edge with S=0 and settle counter cnt=0.
REQ-013 In SCAN, cnt SHALL increment each cycle; when cnt==SETTLE, Y SHALL be written into shadow bit S, cnt SHALL clear, and S SHALL increment.
REQ-014 When bit 7 is sampled, the block SHALL load data_out from the shadow register (bit 7 = the current Y), set data_valid=1 and enter HOLD; S SHALL return to 0.
REQ-015 data_valid SHALL first be high 8*(SETTLE+1) edges after the edge that samples start (16 for SETTLE=1, 8 for SETTLE=0).
REQ-016 In HOLD, data_out and data_valid SHALL remain stable until data_valid & data_ready are both high at an edge.
REQ-017 On transfer, the block SHALL clear data_valid and go to IDLE; if start=1 on that same edge, it SHALL go directly to SCAN with S=0 (back-to-back scans, no idle bubble).
REQ-018 start SHALL be ignored in SCAN and in HOLD except as given in REQ-017; a scan in progress SHALL NOT restart.
REQ-019 data_ready in IDLE or SCAN SHALL have no effect.
REQ-020 The shadow register SHALL NOT be visible on data_out until the word is complete; partial words SHALL never be presented.

Reset
REQ-021 With rst high, the block SHALL immediately force state=IDLE, S=0, cnt=0, busy=0, data_valid=0, data_out=8'h00 and shadow=8'h00, regardless of clk.
REQ-022 Reset asserted mid-SCAN or in HOLD SHALL discard the partial or pending word; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-023 With macro MUX_SCAN_PARITY_EN defined, the block SHALL add output parity (1 bit), equal to the XOR of data_out, registered alongside data_out, reset 0 and valid with data_valid.
REQ-024 Without MUX_SCAN_PARITY_EN, the parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-025 SETTLE=1, mux81 driven with I=8'hA5, start pulse, data_ready=1 -> S steps 0..7 with each value held 2 cycles, data_valid high 16 cycles after start, data_out=8'hA5, parity=0 when enabled.
REQ-026 SETTLE=0, I=8'h3C, data_ready=0 for 10 cycles after valid -> data_out stays 8'h3C and data_valid stays 1 until data_ready rises; transfer occurs on that edge.
REQ-027 start held high continuously with data_ready=1, I=8'hFF then 8'h01 -> two consecutive words 8'hFF and 8'h01 with no IDLE cycle between them; parity=0 then 1.
REQ-028 Extra start pulses during SCAN and data_ready pulses in IDLE -> no change in S sequence and no spurious data_valid.
REQ-029 rst asserted asynchronously (between clock edges) while S=4 in SCAN -> outputs reset at once; after release with no start, data_valid stays 0 for 40 cycles.
